// File: rtl/layer_scheduler.sv
// Runs the CNN layer engines one after another (arm, run, advance) with a per-layer watchdog,
// and routes the active layer's request onto the shared result BRAM port A.
module layer_scheduler #(
    parameter int NUM_LAYERS = 7,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 200000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    output logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS-1:0]        layer_finish,
    input  logic [NUM_LAYERS-1:0]        lyr_ena,
    input  logic [NUM_LAYERS-1:0]        lyr_wea,
    input  logic [NUM_LAYERS*ADDR_W-1:0] lyr_addra,
    input  logic [NUM_LAYERS*DATA_W-1:0] lyr_dina,
    output logic                         bram_ena,
    output logic                         bram_wea,
    output logic [ADDR_W-1:0]            bram_addra,
    output logic [DATA_W-1:0]            bram_dina,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [3:0]                   cur_layer
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_arm_2nd;
    logic [WD_W-1:0]       r_wd;
    logic [NUM_LAYERS-1:0] r_layer_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_route;
    logic                  w_finish;
    logic                  w_bram_ena;
    logic                  w_bram_wea;
    logic [ADDR_W-1:0]     w_bram_addra;
    logic [DATA_W-1:0]     w_bram_dina;

    function automatic logic [NUM_LAYERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_LAYERS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (idx == IDX_W'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    assign w_route = (r_state == S_ARM) || (r_state == S_RUN);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_finish     = 1'b0;
        w_bram_ena   = 1'b0;
        w_bram_wea   = 1'b0;
        w_bram_addra = '0;
        w_bram_dina  = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_finish = layer_finish[k];
                if (w_route) begin
                    w_bram_ena   = lyr_ena[k];
                    w_bram_wea   = lyr_wea[k];
                    w_bram_addra = lyr_addra[k*ADDR_W +: ADDR_W];
                    w_bram_dina  = lyr_dina[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_arm_2nd  <= 1'b0;
            r_wd       <= '0;
            r_layer_en <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    // abort outranks start even while idle or in error
                    if (start && !abort) begin
                        r_state    <= S_ARM;
                        r_idx      <= '0;
                        r_arm_2nd  <= 1'b0;
                        r_layer_en <= onehot('0);
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_layer_en <= '0;
                        r_busy     <= 1'b0;
                    end else if (r_arm_2nd) begin
                        r_state <= S_RUN;
                        r_wd    <= '0;
                    end else begin
                        r_arm_2nd <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_layer_en <= '0;
                        r_busy     <= 1'b0;
                    end else if (w_finish) begin
                        r_state    <= S_NEXT;
                        r_layer_en <= '0;
                    end else if (r_wd == WD_LAST) begin
                        r_state    <= S_ERR;
                        r_layer_en <= '0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_ARM;
                        r_idx      <= r_idx + IDX_W'(1);
                        r_arm_2nd  <= 1'b0;
                        r_layer_en <= onehot(r_idx + IDX_W'(1));
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_layer_en <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign layer_en   = r_layer_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cur_layer  = 4'(r_idx);
    assign bram_ena   = w_bram_ena;
    assign bram_wea   = w_bram_wea;
    assign bram_addra = w_bram_addra;
    assign bram_dina  = w_bram_dina;

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, 7, number of sequenced layers (conv1, pool1, conv2, pool2, fc1, fc2, fc3).
REQ-002 The block SHALL have parameter ADDR_W, 13, result BRAM address width.
REQ-003 The block SHALL have parameter DATA_W, 16, result BRAM data width.
REQ-004 The block SHALL have parameter TIMEOUT, 200000, maximum RUN cycles per layer before error.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1, one-cycle request to run all layers.
REQ-008 The block SHALL have port abort, input, 1, one-cycle request to stop the current run.
REQ-009 The block SHALL have port layer_en, output, NUM_LAYERS, one-hot enable to the layer engines; bit i = layer i.
REQ-010 The block SHALL have port layer_finish, input, NUM_LAYERS, per-layer finish flags (level, may be stale from a previous run).
REQ-011 The block SHALL have ports lyr_ena, lyr_wea (NUM_LAYERS each), lyr_addra (NUM_LAYERS*ADDR_W) and lyr_dina (NUM_LAYERS*DATA_W), inputs, packed per-layer BRAM requests with layer i in slice i.
REQ-012 The block SHALL have ports bram_ena, bram_wea (1), bram_addra (ADDR_W) and bram_dina (DATA_W), outputs, to the shared result BRAM port A.
REQ-013 The block SHALL have outputs busy (1), done (1, one-cycle pulse), err (1, sticky) and cur_layer (4, index of the active layer).

Function
REQ-014 States SHALL be IDLE, ARM, RUN, NEXT, DONE and ERR.
REQ-015 IDLE: start=1 -> idx=0, ARM; otherwise stay.
REQ-016 ARM SHALL last exactly 2 cycles with layer_en[idx]=1, so the layer clears a stale finish flag; then RUN.
REQ-017 RUN: layer_finish[idx] sampled; when 1 -> layer_en=0 the next cycle, state NEXT.
REQ-018 NEXT: idx==NUM_LAYERS-1 -> DONE; otherwise idx+1 and ARM.
REQ-019 DONE SHALL hold for 1 cycle with done=1, then return to IDLE.
REQ-020 RUN watchdog: the counter SHALL clear on entry to RUN and increment each RUN cycle; count==TIMEOUT-1 without finish -> ERR.
REQ-021 ERR: layer_en=0 and err=1; err SHALL stay set until start, which clears err and begins a new run (idx=0, ARM).
REQ-022 abort=1 in ARM, RUN or NEXT -> IDLE next cycle, with layer_en=0 and no done pulse.
REQ-023 If start and abort are both 1, abort SHALL win in every state.
REQ-024 start SHALL be ignored outside IDLE and ERR.
REQ-025 layer_en SHALL be registered, zero or one-hot, and nonzero only in ARM and RUN.
REQ-026 The BRAM mux SHALL be combinational (zero added latency, preserving the layers' read-latency counting): in ARM/RUN, bram_* = lyr_*[idx] slice; else bram_ena=0, bram_wea=0, bram_addra=0, bram_dina=0.
REQ-027 Requests from non-active layers SHALL be ignored.
REQ-028 busy SHALL be 1 in ARM, RUN and NEXT, else 0.
REQ-029 cur_layer SHALL equal idx, zero-extended.
REQ-030 A layer_finish bit for a non-active layer SHALL have no effect.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, idx=0, watchdog=0, layer_en=0, done=0, err=0 and busy=0.
REQ-032 While rst=0, bram_ena=0 and bram_wea=0 via the mux.
REQ-033 Reset mid-run SHALL drop the enable immediately, with no done pulse.
REQ-034 After rst rises, the first start SHALL be accepted on the next clock edge.

Verification
REQ-035 NUM_LAYERS=3, start at cycle 0, each model layer raises finish 10 cycles after enable -> layer_en = 001, 010, 100 in order; one done pulse; busy low after.
REQ-036 Stale finish: layer_finish=111 held at start, model clears it 1 cycle after enable -> no layer skipped; each layer_en high ≥ 2 cycles.
REQ-037 Mux: active layer 1 drives addr=7480, wea=1, dina=0x00FF; layer 0 drives addr=5880 -> bram_addra=7480, bram_wea=1, same cycle.
REQ-038 TIMEOUT=50, layer 1 never finishes -> ERR after 50 RUN cycles; err=1, layer_en=0; a later start clears err and restarts at layer 0.
REQ-039 abort in RUN of layer 2, with start in the same cycle -> IDLE, layer_en=0, no done, start ignored.
REQ-040 rst pulled low mid-RUN between clock edges -> outputs reset before the next edge; bram_ena=0.
